// File: rtl/clken_pkg.sv
// ---------------------------------------------------------------------------
// clken_pkg
// Shared types and limits for the clock-enable generator: the halt FSM state
// encoding, the 3-bit phase type and the parameter range limits.
// ---------------------------------------------------------------------------
package clken_pkg;

    localparam int unsigned MAX_NUM_CH = 8;
    localparam int unsigned MAX_PHASES = 8;
    localparam int unsigned MAX_DIV    = 16;
    localparam int unsigned PHASE_W    = 3;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_STEP    = 2'd3
    } halt_state_e;

endpackage

// File: rtl/clken_phase_ctr.sv
// ---------------------------------------------------------------------------
// clken_phase_ctr
// Oscillator divider plus microcycle phase counter.
// Ports:
//   clk_i      oscillator clock
//   rst_i      asynchronous active-high reset
//   advance_i  phase may advance on this base tick (running and not stalled)
//   tick_o     base tick, high while the divider sits at DIV-1
//   phase_o    current phase, 0..PHASES-1
// ---------------------------------------------------------------------------
module clken_phase_ctr
    import clken_pkg::*;
#(
    parameter int unsigned PHASES = 2,
    parameter int unsigned DIV    = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   advance_i,
    output logic   tick_o,
    output phase_t phase_o
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    phase_t           phase_q, phase_d;
    logic             tick;

    // With DIV=1 the counter is pinned at 0, so the tick is permanently high.
    assign tick = (div_q == DIV_W'(DIV - 1));

    // Tick is masked during reset so every pulse output reads 0 at once.
    assign tick_o  = tick & ~rst_i;
    assign phase_o = phase_q;

    // Divider wrap and phase advance.
    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        phase_d = phase_q;
        if (tick && advance_i) begin
            phase_d = (phase_q == phase_t'(PHASES - 1)) ? '0 : phase_q + phase_t'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            phase_q <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/clken_gen.sv
// ---------------------------------------------------------------------------
// clken_gen
// Microcycle clock-enable generator with halt / single-step control.
// Build option: define CLKEN_GEN_STALL_CNT_EN to implement the saturating
// stalled-tick counter; otherwise stall_cnt_h is tied to 0.
// Ports:
//   cpu_osc_in_h  oscillator clock
//   sac_reset_h   asynchronous active-high reset
//   mem_stall_h   global stall, freezes the microcycle
//   ch_stall_h    per-channel stall
//   ch_phase_h    per-channel phase select, 3 bits per channel
//   halt_l        halt request (active low)
//   step_h        single-step request, honoured while halted
//   base_tick_h   base tick pulse
//   phase_h       current phase
//   ucyc_end_h    tick completing a microcycle
//   ch_clk_en_h   per-channel clock enables
//   halted_h      halt FSM is in HALTED
//   stall_cnt_h   saturating count of stalled base ticks
// ---------------------------------------------------------------------------
module clken_gen
    import clken_pkg::*;
#(
    parameter int unsigned              NUM_CH    = 3,
    parameter int unsigned              PHASES    = 2,
    parameter int unsigned              DIV       = 2,
    parameter logic [NUM_CH-1:0]        FREE_MASK = NUM_CH'(1),
    parameter int unsigned              STALL_W   = 8
) (
    input  logic                cpu_osc_in_h,
    input  logic                sac_reset_h,
    input  logic                mem_stall_h,
    input  logic [NUM_CH-1:0]   ch_stall_h,
    input  logic [NUM_CH*3-1:0] ch_phase_h,
    input  logic                halt_l,
    input  logic                step_h,
    output logic                base_tick_h,
    output phase_t              phase_h,
    output logic                ucyc_end_h,
    output logic [NUM_CH-1:0]   ch_clk_en_h,
    output logic                halted_h,
    output logic [STALL_W-1:0]  stall_cnt_h
);

    if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH || PHASES < 2 || PHASES > MAX_PHASES ||
        DIV < 1 || DIV > MAX_DIV) begin : g_cfg_check
        $error("clken_gen: parameter out of range");
    end

    halt_state_e state_q, state_d;
    logic        running;
    logic        advance;

    // HALTING keeps running so the current microcycle completes before halting.
    assign running  = (state_q != ST_HALTED);
    assign advance  = running & ~mem_stall_h;
    assign halted_h = (state_q == ST_HALTED);

    clken_phase_ctr #(
        .PHASES (PHASES),
        .DIV    (DIV)
    ) u_phase_ctr (
        .clk_i     (cpu_osc_in_h),
        .rst_i     (sac_reset_h),
        .advance_i (advance),
        .tick_o    (base_tick_h),
        .phase_o   (phase_h)
    );

    assign ucyc_end_h = base_tick_h & advance & (phase_h == phase_t'(PHASES - 1));

    // Halt FSM next state; halt is only taken at a microcycle boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (!halt_l)    state_d = ST_HALTING;
            ST_HALTING: if (ucyc_end_h) state_d = ST_HALTED;
            ST_HALTED: begin
                if (halt_l)      state_d = ST_RUN;
                else if (step_h) state_d = ST_STEP;
            end
            ST_STEP:    if (ucyc_end_h) state_d = ST_HALTED;
            default:                    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge cpu_osc_in_h or posedge sac_reset_h) begin
        if (sac_reset_h) state_q <= ST_RUN;
        else             state_q <= state_d;
    end

    // Channel gating; free channels ignore the global stall and the halt.
    always_comb begin
        phase_t sel;
        sel         = '0;
        ch_clk_en_h = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sel = ch_phase_h[3*i +: 3];
            ch_clk_en_h[i] = base_tick_h & (sel == phase_h) & (32'(sel) < PHASES) &
                             ~ch_stall_h[i] & (FREE_MASK[i] | advance);
        end
    end

`ifdef CLKEN_GEN_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count stalled ticks while running; microcycle end clears and takes priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ucyc_end_h) begin
            stall_cnt_d = '0;
        end else if (base_tick_h && running && mem_stall_h && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge cpu_osc_in_h or posedge sac_reset_h) begin
        if (sac_reset_h) stall_cnt_q <= '0;
        else             stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_h = stall_cnt_q;
`else
    assign stall_cnt_h = '0;
`endif

endmodule

// File: tb/tb_clken_gen.sv
// ---------------------------------------------------------------------------
// tb_clken_gen
// Self-checking bench for clken_gen (NUM_CH=3, PHASES=2, DIV=2, STALL_W=2,
// channel 0 free-running). A cycle model pushes the expected outputs when a
// cycle's inputs are driven; each scenario pops and compares them, plus
// scenario-specific pulse-count and timing checks.
// ---------------------------------------------------------------------------
module tb_clken_gen;

    localparam int NUM_CH  = 3;
    localparam int PHASES  = 2;
    localparam int DIV     = 2;
    localparam int STALL_W = 2;
    localparam int STALL_MAX = 3;
    localparam logic [2:0] FREE   = 3'b001;
    localparam logic [8:0] PH_DEF = {3'd1, 3'd1, 3'd0};

    localparam int S_RUN = 0, S_HALTING = 1, S_HALTED = 2, S_STEP = 3;

`ifdef CLKEN_GEN_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       base_tick;
        logic [2:0] phase;
        logic       ucyc;
        logic [2:0] ch;
        logic       halted;
        logic [1:0] stall;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_stall = 1'b0;
    logic       halt_l = 1'b1;
    logic       step = 1'b0;
    logic [2:0] ch_stall = 3'b000;
    logic [8:0] ch_phase = PH_DEF;

    logic       base_tick_h;
    logic [2:0] phase_h;
    logic       ucyc_end_h;
    logic [2:0] ch_clk_en_h;
    logic       halted_h;
    logic [1:0] stall_cnt_h;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_div = 0, m_phase = 0, m_st = S_RUN, m_stall = 0;
    out_t exp_q[$];

    always #5 clk = ~clk;

    clken_gen #(
        .NUM_CH    (NUM_CH),
        .PHASES    (PHASES),
        .DIV       (DIV),
        .FREE_MASK (FREE),
        .STALL_W   (STALL_W)
    ) dut (
        .cpu_osc_in_h (clk),
        .sac_reset_h  (rst),
        .mem_stall_h  (mem_stall),
        .ch_stall_h   (ch_stall),
        .ch_phase_h   (ch_phase),
        .halt_l       (halt_l),
        .step_h       (step),
        .base_tick_h  (base_tick_h),
        .phase_h      (phase_h),
        .ucyc_end_h   (ucyc_end_h),
        .ch_clk_en_h  (ch_clk_en_h),
        .halted_h     (halted_h),
        .stall_cnt_h  (stall_cnt_h)
    );

    function automatic out_t sample();
        out_t o;
        o.base_tick = base_tick_h;
        o.phase     = phase_h;
        o.ucyc      = ucyc_end_h;
        o.ch        = ch_clk_en_h;
        o.halted    = halted_h;
        o.stall     = stall_cnt_h;
        return o;
    endfunction

    // Expected outputs for the current cycle from model state and inputs.
    function automatic out_t model_out();
        out_t o;
        bit   tk, run, adv;
        int   sel;
        o = '0;
        if (rst) return o;
        tk  = (m_div == DIV - 1);
        run = (m_st != S_HALTED);
        adv = run && !mem_stall;
        o.base_tick = tk;
        o.phase     = 3'(m_phase);
        o.ucyc      = tk && adv && (m_phase == PHASES - 1);
        for (int i = 0; i < NUM_CH; i++) begin
            sel = int'(ch_phase[3*i +: 3]);
            o.ch[i] = tk && (sel == m_phase) && (sel < PHASES) && !ch_stall[i] &&
                      (FREE[i] || adv);
        end
        o.halted = (m_st == S_HALTED);
        o.stall  = CNT_EN ? 2'(m_stall) : 2'd0;
        return o;
    endfunction

    // Model state update at the rising edge.
    task automatic model_clock();
        bit tk, run, adv, ucyc;
        if (rst) begin
            m_div = 0; m_phase = 0; m_st = S_RUN; m_stall = 0;
            return;
        end
        tk   = (m_div == DIV - 1);
        run  = (m_st != S_HALTED);
        adv  = run && !mem_stall;
        ucyc = tk && adv && (m_phase == PHASES - 1);
        if (tk && adv) m_phase = (m_phase + 1) % PHASES;
        if (ucyc) m_stall = 0;
        else if (tk && run && mem_stall && m_stall < STALL_MAX) m_stall++;
        case (m_st)
            S_RUN:     if (!halt_l) m_st = S_HALTING;
            S_HALTING: if (ucyc) m_st = S_HALTED;
            S_HALTED:  if (halt_l) m_st = S_RUN; else if (step) m_st = S_STEP;
            default:   if (ucyc) m_st = S_HALTED;
        endcase
        m_div = (m_div + 1) % DIV;
    endtask

    // Apply one cycle's inputs (at the falling edge) and queue the expectation.
    task automatic drive(input bit ms, input logic [2:0] cs, input bit hl, input bit st);
        mem_stall = ms;
        ch_stall  = cs;
        halt_l    = hl;
        step      = st;
        exp_q.push_back(model_out());
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        out_t got, e;
        int   first = 0;
        repeat (2) @(negedge clk);
        model_clock();
        #1 got = sample();
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", got); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, 3'b000, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL reset_release c=%0d got=%h exp=%h", c, got, e); end
            if (got.base_tick && first == 0) first = c;
            advance();
        end
        n_tests++;
        if (first !== DIV) begin n_fail++; $display("FAIL first_tick got=%0d exp=%0d", first, DIV); end
    endtask

    task automatic test_free_run();
        out_t got, e;
        int   last0 = -1, n0 = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 3'b000, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL free_run c=%0d got=%h exp=%h", c, got, e); end
            if (got.ch[0]) begin
                if (last0 >= 0) begin
                    n_tests++;
                    if (c - last0 !== 4) begin n_fail++; $display("FAIL ch0_period got=%0d exp=4", c - last0); end
                end
                last0 = c; n0++;
            end
            for (int i = 1; i < NUM_CH; i++) begin
                if (got.ch[i] && last0 >= 0) begin
                    n_tests++;
                    if (c - last0 !== 2) begin n_fail++; $display("FAIL ch%0d_lag got=%0d exp=2", i, c - last0); end
                end
            end
            advance();
        end
        n_tests++;
        if (n0 !== 4) begin n_fail++; $display("FAIL ch0_count got=%0d exp=4", n0); end
    endtask

    task automatic test_ch_gating();
        out_t got, e;
        int   n0 = 0, n1 = 0, n2 = 0;
        ch_phase = {3'd5, 3'd1, 3'd0};
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, (c < 8) ? 3'b010 : 3'b001, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL ch_gating c=%0d got=%h exp=%h", c, got, e); end
            n0 += int'(got.ch[0]); n1 += int'(got.ch[1]); n2 += int'(got.ch[2]);
            advance();
        end
        ch_phase = PH_DEF;
        n_tests++;
        if (n0 !== 2 || n1 !== 2 || n2 !== 0) begin
            n_fail++; $display("FAIL ch_gating_counts got=%0d/%0d/%0d exp=2/2/0", n0, n1, n2);
        end
    endtask

    task automatic test_mem_stall();
        out_t got, e;
        int   stage = 0, ns = 0, n0 = 0, n12 = 0;
        bit   ms, chk_cnt = 0, chk_clr = 0;
        for (int c = 0; c < 40; c++) begin
            if (stage == 0 && m_div == 0 && m_phase == 0) stage = 1;
            ms = (stage == 1);
            drive(ms, 3'b000, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL mem_stall c=%0d got=%h exp=%h", c, got, e); end
            if (chk_cnt) begin
                n_tests++; chk_cnt = 0;
                if (got.stall !== (CNT_EN ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL stall_cnt3 got=%0d", got.stall); end
            end
            if (chk_clr) begin
                n_tests++; chk_clr = 0; stage = 3;
                if (got.stall !== 2'd0) begin n_fail++; $display("FAIL stall_clear got=%0d exp=0", got.stall); end
            end
            if (ms) begin
                n0 += int'(got.ch[0]); n12 += int'(got.ch[1]) + int'(got.ch[2]);
                if (got.base_tick) ns++;
                if (ns == 3 && got.base_tick) begin stage = 2; chk_cnt = 1; end
            end else if (stage == 2 && got.ucyc) chk_clr = 1;
            advance();
            if (stage == 3) break;
        end
        n_tests++;
        if (stage != 3 || n0 !== 3 || n12 !== 0) begin
            n_fail++; $display("FAIL mem_stall_seq stage=%0d ch0=%0d ch12=%0d exp=3/3/0", stage, n0, n12);
        end
    endtask

    task automatic test_saturation();
        out_t got, e;
        int   ns = 0;
        bit   ms;
        while (m_div != 0) begin
            drive(1'b0, 3'b000, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL sat_align got=%h exp=%h", got, e); end
            advance();
        end
        for (int c = 0; c < 11; c++) begin
            ms = (c < 10);
            drive(ms, 3'b000, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL saturation c=%0d got=%h exp=%h", c, got, e); end
            if (ms && got.base_tick) ns++;
            if (!ms) begin
                n_tests++;
                if (ns !== 5 || got.stall !== (CNT_EN ? 2'd3 : 2'd0)) begin
                    n_fail++; $display("FAIL stall_sat ticks=%0d got=%0d", ns, got.stall);
                end
            end
            advance();
        end
    endtask

    task automatic test_halt();
        out_t got, e;
        int   stage = 0, hc = 0, n0 = 0, n12 = 0, nu = 0;
        bit   prev_u = 0;
        for (int c = 0; c < 40; c++) begin
            if (stage == 0 && m_div == 0 && m_phase == 0) stage = 1;
            drive(1'b0, 3'b000, (stage == 0), 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL halt c=%0d got=%h exp=%h", c, got, e); end
            if (stage == 1 && got.halted) begin
                stage = 2; n_tests++;
                if (prev_u !== 1'b1 || got.phase !== 3'd0) begin
                    n_fail++; $display("FAIL halt_entry prev_ucyc=%0d phase=%0d exp=1/0", prev_u, got.phase);
                end
            end
            if (stage == 2) begin
                hc++; n0 += int'(got.ch[0]); n12 += int'(got.ch[1]) + int'(got.ch[2]); nu += int'(got.ucyc);
            end
            prev_u = got.ucyc;
            advance();
            if (hc == 8) break;
        end
        n_tests++;
        if (hc !== 8 || n0 !== 4 || n12 !== 0 || nu !== 0) begin
            n_fail++; $display("FAIL halted_run cyc=%0d ch0=%0d ch12=%0d ucyc=%0d exp=8/4/0/0", hc, n0, n12, nu);
        end
    endtask

    task automatic test_step();
        out_t got, e;
        int   nu, n1, n2;
        // Plain step, then a step stretched by a global stall.
        for (int v = 0; v < 2; v++) begin
            nu = 0; n1 = 0; n2 = 0;
            for (int c = 0; c < 18; c++) begin
                drive((v == 1) && c >= 1 && c <= 4, 3'b000, 1'b0, (c == 0));
                #1 got = sample(); e = exp_q.pop_front();
                n_tests++;
                if (got !== e) begin n_fail++; $display("FAIL step%0d c=%0d got=%h exp=%h", v, c, got, e); end
                nu += int'(got.ucyc); n1 += int'(got.ch[1]); n2 += int'(got.ch[2]);
                advance();
            end
            n_tests++;
            if (nu !== 1 || n1 !== 1 || n2 !== 1 || got.halted !== 1'b1) begin
                n_fail++; $display("FAIL step%0d_counts ucyc=%0d ch1=%0d ch2=%0d halted=%0d exp=1/1/1/1", v, nu, n1, n2, got.halted);
            end
        end
        // Step and release together: release wins.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 3'b000, 1'b1, (c == 0));
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL step_release c=%0d got=%h exp=%h", c, got, e); end
            if (c == 1) begin
                n_tests++;
                if (got.halted !== 1'b0) begin n_fail++; $display("FAIL step_release_run got=%0d exp=0", got.halted); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        out_t got, e;
        int   stage = 0, hc = 0;
        for (int c = 0; c < 20; c++) begin
            if (stage == 0 && m_div == 0 && m_phase == 1) stage = 1;
            drive(1'b0, 3'b000, (stage != 1), 1'b0);
            if (stage == 1) stage = 2;
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL halting_release c=%0d got=%h exp=%h", c, got, e); end
            hc += int'(got.halted);
            advance();
        end
        n_tests++;
        if (stage != 2 || hc !== 1) begin n_fail++; $display("FAIL halting_release_cnt halted=%0d exp=1", hc); end
    endtask

    task automatic test_reset_mid_step();
        out_t got, e;
        int   stage = 0, cnt = 0, first = 0;
        for (int c = 0; c < 40 && stage < 4; c++) begin
            if (stage == 0 && m_div == 0 && m_phase == 0) stage = 1;
            drive(1'b0, 3'b000, (stage == 0), (stage == 2));
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL rst_step_setup c=%0d got=%h exp=%h", c, got, e); end
            if (stage == 3) begin cnt++; if (cnt == 2) stage = 4; end
            if (stage == 2) stage = 3;
            if (stage == 1 && got.halted) stage = 2;
            advance();
        end
        n_tests++;
        if (stage != 4 || m_st != S_STEP) begin n_fail++; $display("FAIL rst_step_reach stage=%0d state=%0d exp=4/3", stage, m_st); end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        #1 got = sample(); e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL rst_step_pre got=%h exp=%h", got, e); end
        #1 rst = 1'b1;
        #1 got = sample();
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_async got=%h exp=0", got); end
        advance();
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        #1 got = sample(); e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
        advance();
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, 3'b000, 1'b1, 1'b0);
            #1 got = sample(); e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin n_fail++; $display("FAIL rst_step_release c=%0d got=%h exp=%h", c, got, e); end
            if (got.base_tick && first == 0) first = c;
            advance();
        end
        n_tests++;
        if (first !== DIV || m_st != S_RUN) begin
            n_fail++; $display("FAIL rst_step_first_tick got=%0d exp=%0d", first, DIV);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ch_gating();
        test_mem_stall();
        test_saturation();
        test_halt();
        test_step();
        test_back_to_back();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
